// File: rtl/opb_master_pkg.sv
// Shared definitions for the OPB master bridge.
// Holds the FSM state encoding, the default bus widths and the default
// timeout / retry limits used by the top level and its interface.
package opb_master_pkg;

  localparam int unsigned OpbAwidth   = 32;
  localparam int unsigned OpbDwidth   = 32;
  localparam int unsigned DefTimeout  = 16;
  localparam int unsigned DefMaxRetry = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StXfer = 2'd2,
    StResp = 2'd3
  } opb_state_e;

endpackage

// File: rtl/opb_simulink2opb_master_if.sv
// Bundle of the user command/response handshake and the OPB master bus.
// Modport master: the bridge view (drives cmd_ready, rsp_*, M_*).
// Modport slave : the environment view (drives cmd_*, OPB_*).
// Bus vectors use OPB big-endian bit numbering ([0] is the MSB).
interface opb_simulink2opb_master_if
  import opb_master_pkg::*;
#(
  parameter int unsigned AWidth = OpbAwidth,
  parameter int unsigned DWidth = OpbDwidth
);
  localparam int unsigned BeWidth = DWidth / 8;

  // User command side
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_rnw;
  logic [0:AWidth-1]   cmd_addr;
  logic [0:DWidth-1]   cmd_wdata;
  logic [0:BeWidth-1]  cmd_be;
  // User response side
  logic                rsp_valid;
  logic [0:DWidth-1]   rsp_rdata;
  logic                rsp_err;
  logic                rsp_tout;
  // OPB master side
  logic                M_request;
  logic                OPB_MGrant;
  logic                M_select;
  logic                M_RNW;
  logic                M_seqAddr;
  logic                M_busLock;
  logic [0:AWidth-1]   M_ABus;
  logic [0:BeWidth-1]  M_BE;
  logic [0:DWidth-1]   M_DBus;
  logic [0:DWidth-1]   OPB_DBus;
  logic                OPB_xferAck;
  logic                OPB_errAck;
  logic                OPB_retry;
  logic                OPB_toutSup;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be,
    input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    output M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be,
    output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    input  M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus
  );

endinterface

// File: rtl/opb_tout_counter.sv
// Transfer timeout counter.
// clr_i has priority and zeroes the count; en_i increments; otherwise holds.
// tc_o flags the enabled cycle whose increment reaches Limit, so a caller
// acting on tc_o leaves after exactly Limit enabled cycles.
// Ports: clk_i, rst_ni (async active-low), clr_i, en_i, tc_o.
module opb_tout_counter #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned Cw = $clog2(Limit + 1);

  logic [Cw-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  assign tc_o = en_i && !clr_i && (count_q == Cw'(Limit - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/opb_simulink2opb_master.sv
// Single-beat OPB master bridging a simple valid/ready command port onto OPB.
// Ports: OPB_Clk (clock), OPB_Rst_n (async active-low reset), bus (master
// modport carrying the command/response handshake and OPB master signals).
// Flow: IDLE accepts a command, REQ requests the bus, XFER drives the cycle
// until xferAck / retry / self-timeout, RESP pulses rsp_valid for one cycle.
module opb_simulink2opb_master
  import opb_master_pkg::*;
#(
  parameter int unsigned C_OPB_AWIDTH = OpbAwidth,
  parameter int unsigned C_OPB_DWIDTH = OpbDwidth,
  parameter int unsigned C_TIMEOUT    = DefTimeout,
  parameter int unsigned C_MAX_RETRY  = DefMaxRetry
) (
  input logic                        OPB_Clk,
  input logic                        OPB_Rst_n,
  opb_simulink2opb_master_if.master  bus
);
  localparam int unsigned BeWidth = C_OPB_DWIDTH / 8;
  // Must hold C_MAX_RETRY + 1 so the "exceeded" value is representable.
  localparam int unsigned RetryW  = $clog2(C_MAX_RETRY + 2);

  opb_state_e state_q, state_d;

  logic                     rnw_q, rnw_d;
  logic [0:C_OPB_AWIDTH-1]  addr_q, addr_d;
  logic [0:C_OPB_DWIDTH-1]  wdata_q, wdata_d;
  logic [0:BeWidth-1]       be_q, be_d;
  logic [RetryW-1:0]        retry_q, retry_d;
  logic [RetryW-1:0]        retry_inc;
  logic [0:C_OPB_DWIDTH-1]  rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     tout_q, tout_d;

  logic xfer;
  logic tout_tc;

  assign xfer      = (state_q == StXfer);
  assign retry_inc = retry_q + 1'b1;

  // Counter is held clear outside XFER so every XFER entry starts from zero.
  opb_tout_counter #(
    .Limit (C_TIMEOUT)
  ) u_tout_counter (
    .clk_i  (OPB_Clk),
    .rst_ni (OPB_Rst_n),
    .clr_i  (!xfer),
    .en_i   (xfer && !bus.OPB_toutSup),
    .tc_o   (tout_tc)
  );

  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    retry_d = retry_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tout_d  = tout_q;

    unique case (state_q)
      StIdle: begin
        retry_d = '0;
        if (bus.cmd_valid) begin
          rnw_d   = bus.cmd_rnw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          be_d    = bus.cmd_be;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.OPB_MGrant) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Priority: xferAck over retry over self-timeout.
        if (bus.OPB_xferAck) begin
          if (rnw_q) begin
            rdata_d = bus.OPB_DBus;
          end
          err_d   = bus.OPB_errAck;
          tout_d  = 1'b0;
          state_d = StResp;
        end else if (bus.OPB_retry) begin
          retry_d = retry_inc;
          if (retry_inc > RetryW'(C_MAX_RETRY)) begin
            err_d   = 1'b1;
            tout_d  = 1'b0;
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end else if (tout_tc) begin
          err_d   = 1'b0;
          tout_d  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= StIdle;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      retry_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      retry_q <= retry_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  // OPB is a wired-OR bus: every master output must be zero when not selected.
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.M_request = (state_q == StReq);
  assign bus.M_select  = xfer;
  assign bus.M_RNW     = xfer && rnw_q;
  assign bus.M_ABus    = xfer ? addr_q : '0;
  assign bus.M_BE      = xfer ? be_q : '0;
  assign bus.M_DBus    = (xfer && !rnw_q) ? wdata_q : '0;
  assign bus.M_seqAddr = 1'b0;
  assign bus.M_busLock = 1'b0;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_tout  = tout_q;

endmodule

// File: tb/tb_opb_simulink2opb_master.sv
// Bench for the OPB master bridge: directed and randomized transactions with
// a scripted OPB slave, checked against a transaction-level expectation model.
module tb_opb_simulink2opb_master;
  localparam int Timeout  = 16;
  localparam int MaxRetry = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  opb_simulink2opb_master_if #(.AWidth(32), .DWidth(32)) bus_if ();

  opb_simulink2opb_master #(
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_TIMEOUT    (Timeout),
    .C_MAX_RETRY  (MaxRetry)
  ) dut (
    .OPB_Clk   (clk),
    .OPB_Rst_n (rst_n),
    .bus       (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    bus_if.OPB_MGrant  = 1'b0;
    bus_if.OPB_xferAck = 1'b0;
    bus_if.OPB_errAck  = 1'b0;
    bus_if.OPB_retry   = 1'b0;
    bus_if.OPB_toutSup = 1'b0;
    bus_if.OPB_DBus    = 32'h0;
  endtask

  // One command with a scripted slave. Slave behaviour per attempt:
  // grant after grant_dly REQ cycles; the first n_retry attempts get retry
  // on their first XFER cycle; the final attempt holds toutSup for sup
  // cycles and acks on XFER cycle ack_at (0 = never).
  task automatic run_txn(input string tag, input bit rnw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int grant_dly, input int n_retry, input int ack_at,
                         input bit err_ack, input int sup, input logic [31:0] rd);
    bit exp_err, exp_tout, got, bus_ok, prev_req, prev_sel;
    logic [31:0] exp_rdata;
    int exp_phases, exp_last;
    int req_phases, first_req, phase_req, attempt, xc, last_xc, first_sel;

    // Expected outcome from the command/response rules.
    if (n_retry > MaxRetry) begin
      exp_err = 1'b1; exp_tout = 1'b0; exp_rdata = model_rdata;
      exp_phases = MaxRetry + 1; exp_last = 1;
    end else begin
      exp_phases = n_retry + 1;
      if (ack_at != 0 && ack_at <= sup + Timeout) begin
        exp_err = err_ack; exp_tout = 1'b0;
        exp_rdata = rnw ? rd : model_rdata; exp_last = ack_at;
      end else begin
        exp_err = 1'b0; exp_tout = 1'b1; exp_rdata = model_rdata;
        exp_last = sup + Timeout;
      end
    end

    got = 0; bus_ok = 1; prev_req = 0; prev_sel = 0;
    req_phases = 0; first_req = 0; phase_req = 0; attempt = 0; xc = 0;
    last_xc = 0; first_sel = 0;

    @(negedge clk);
    check({tag, "_ready"}, bus_if.cmd_ready, 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_rnw   = rnw;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    bus_if.cmd_be    = be;

    for (int iter = 1; iter <= 600 && !got; iter++) begin
      @(negedge clk);
      slave_idle();
      if (bus_if.rsp_valid) begin
        got = 1;
        bus_if.cmd_valid = 1'b0;
      end else begin
        // Garbage commands while busy must be ignored.
        bus_if.cmd_valid = 1'($urandom_range(0, 1));
        bus_if.cmd_rnw   = 1'($urandom_range(0, 1));
        bus_if.cmd_addr  = $urandom;
        bus_if.cmd_wdata = $urandom;
        bus_if.cmd_be    = 4'($urandom);
        bus_if.OPB_DBus  = $urandom;
        if (bus_if.M_seqAddr !== 1'b0 || bus_if.M_busLock !== 1'b0) bus_ok = 0;
        if (bus_if.M_select) begin
          if (bus_if.M_ABus !== addr || bus_if.M_BE !== be || bus_if.M_RNW !== rnw ||
              bus_if.M_DBus !== (rnw ? 32'h0 : wdata)) bus_ok = 0;
        end else begin
          if (bus_if.M_ABus !== 32'h0 || bus_if.M_BE !== 4'h0 || bus_if.M_RNW !== 1'b0 ||
              bus_if.M_DBus !== 32'h0) bus_ok = 0;
        end
        if (bus_if.M_request) begin
          if (!prev_req) begin
            req_phases++;
            phase_req = 0;
          end
          phase_req++;
          if (req_phases == 1) first_req++;
          if (phase_req >= grant_dly) bus_if.OPB_MGrant = 1'b1;
        end
        if (bus_if.M_select) begin
          if (!prev_sel) begin
            attempt++;
            xc = 0;
          end
          xc++;
          last_xc = xc;
          if (first_sel == 0) first_sel = iter;
          if (attempt <= n_retry && xc == 1) begin
            bus_if.OPB_retry = 1'b1;
          end else begin
            if (xc <= sup) bus_if.OPB_toutSup = 1'b1;
            if (ack_at != 0 && xc == ack_at) begin
              bus_if.OPB_xferAck = 1'b1;
              bus_if.OPB_errAck  = err_ack;
              bus_if.OPB_DBus    = rd;
              bus_if.OPB_retry   = 1'($urandom_range(0, 1));
            end
          end
        end
        prev_req = bus_if.M_request;
        prev_sel = bus_if.M_select;
      end
    end

    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_rdata"}, bus_if.rsp_rdata, exp_rdata);
    check({tag, "_err"}, bus_if.rsp_err, exp_err);
    check({tag, "_tout"}, bus_if.rsp_tout, exp_tout);
    check({tag, "_req_phases"}, req_phases, exp_phases);
    check({tag, "_first_req_cycles"}, first_req, grant_dly);
    check({tag, "_latency"}, first_sel, grant_dly + 1);
    check({tag, "_last_xfer_cycles"}, last_xc, exp_last);
    check({tag, "_bus_rules"}, bus_ok, 1);
    @(negedge clk);
    check({tag, "_pulse_one"}, bus_if.rsp_valid, 0);
    check({tag, "_idle_again"}, bus_if.cmd_ready, 1);
    check({tag, "_rdata_hold"}, bus_if.rsp_rdata, exp_rdata);
    model_rdata = exp_rdata;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rnw   = 1'b0;
    bus_if.cmd_addr  = 32'h0;
    bus_if.cmd_wdata = 32'h0;
    bus_if.cmd_be    = 4'h0;
    slave_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", bus_if.cmd_ready, 1);
    check("rst_rsp_valid", bus_if.rsp_valid, 0);
    check("rst_m_request", bus_if.M_request, 0);
    check("rst_m_select", bus_if.M_select, 0);
    check("rst_m_abus", bus_if.M_ABus, 0);
    check("rst_rsp_rdata", bus_if.rsp_rdata, 0);
    check("rst_rsp_err_tout", {bus_if.rsp_err, bus_if.rsp_tout}, 0);

    run_txn("read_basic", 1, 32'h01008400, 32'h0, 4'hF, 1, 0, 3, 0, 0, 32'hDEADBEEF);
    run_txn("write_basic", 0, 32'h01008404, 32'h12345678, 4'hF, 1, 0, 2, 0, 0, 32'hA5A5A5A5);
    run_txn("no_ack_tout", 1, 32'h01008408, 32'h0, 4'hF, 1, 0, 0, 0, 0, 32'h11111111);
    run_txn("tout_sup_40", 1, 32'h0100840C, 32'h0, 4'hF, 1, 0, 41, 0, 40, 32'hCAFEF00D);
    run_txn("retry_x4", 1, 32'h01008410, 32'h0, 4'hF, 1, 4, 1, 0, 0, 32'h22222222);
    run_txn("retry_x2_ok", 1, 32'h01008414, 32'h0, 4'hF, 1, 2, 1, 0, 0, 32'h33333333);
    run_txn("grant_dly5", 0, 32'h01008418, 32'h87654321, 4'h3, 5, 0, 1, 0, 0, 32'h0);
    run_txn("err_ack", 1, 32'h0100841C, 32'h0, 4'hC, 2, 0, 4, 1, 0, 32'h44444444);
    run_txn("ack_at_limit", 1, 32'h01008420, 32'h0, 4'hF, 1, 0, 16, 0, 0, 32'h55555555);

    for (int i = 0; i < 16; i++) begin
      int gd, nr, aa, sp;
      bit ea, rw;
      gd = $urandom_range(1, 6);
      nr = ($urandom_range(0, 4) == 0) ? 4 : $urandom_range(0, 3);
      aa = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      sp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      ea = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom_range(0, 1));
      run_txn($sformatf("rand%0d", i), rw, $urandom, $urandom, 4'($urandom), gd, nr, aa, ea,
              sp, $urandom);
    end

    // Reset while a read is in XFER.
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_rnw   = 1'b1;
    bus_if.cmd_addr  = 32'h01008500;
    @(negedge clk);
    bus_if.cmd_valid  = 1'b0;
    bus_if.OPB_MGrant = 1'b1;
    for (int i = 0; i < 20 && !bus_if.M_select; i++) @(negedge clk);
    check("rstx_reached_xfer", bus_if.M_select, 1);
    bus_if.OPB_MGrant = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstx_select_drop", bus_if.M_select, 0);
    check("rstx_request_drop", bus_if.M_request, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.rsp_valid) seen = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.rsp_valid) seen = 1;
    end
    check("rstx_no_rsp", seen, 0);
    check("rstx_ready", bus_if.cmd_ready, 1);
    check("rstx_rdata_cleared", bus_if.rsp_rdata, 0);
    model_rdata = 32'h0;

    run_txn("after_reset", 1, 32'h01008504, 32'h0, 4'hF, 1, 0, 1, 0, 0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/opb_simulink2opb_master.md
OPB_SIMULINK2OPB_MASTER -- requirements
Module: opb_simulink2opb_master

Interface
- REQ-001 SHALL have parameter C_OPB_AWIDTH, default 32, address width.
- REQ-002 SHALL have parameter C_OPB_DWIDTH, default 32, data width.
- REQ-003 SHALL have parameter C_TIMEOUT, default 16, XFER cycles before self-abort.
- REQ-004 SHALL have parameter C_MAX_RETRY, default 3, retries tolerated per command.
- REQ-005 SHALL have ports:
  OPB_Clk  in  1  sole clock;
  OPB_Rst_n  in  1  asynchronous, active-low reset;
  cmd_valid  in  1  user command strobe;
  cmd_ready  out  1  high only in IDLE;
  cmd_rnw  in  1  1=read, 0=write;
  cmd_addr  in  [0:31]  target address;
  cmd_wdata  in  [0:31]  write data;
  cmd_be  in  [0:3]  byte enables;
  rsp_valid  out  1  one-cycle completion pulse;
  rsp_rdata  out  [0:31]  read data;
  rsp_err  out  1  errAck or retry limit exceeded;
  rsp_tout  out  1  self-timeout;
  M_request  out  1  bus request;
  OPB_MGrant  in  1  arbiter grant;
  M_select, M_RNW, M_seqAddr, M_busLock  out  1  OPB master controls;
  M_ABus  out  [0:31];  M_BE  out  [0:3];  M_DBus  out  [0:31];
  OPB_DBus  in  [0:31];  OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup  in  1.

Function
- REQ-006 SHALL implement states IDLE, REQ, XFER, RESP.
- REQ-007 IDLE: cmd_ready=1; cmd_valid=1 latches rnw/addr/wdata/be and moves to REQ; retry count cleared.
- REQ-008 REQ: M_request=1; OPB_MGrant sampled high moves to XFER next cycle; M_request drops that same next cycle.
- REQ-009 XFER: M_select=1 with M_ABus, M_BE, M_RNW, and (writes only) M_DBus driven from the latched command.
- REQ-010 XFER, OPB_xferAck=1: capture OPB_DBus into rsp_rdata on reads; set rsp_err=OPB_errAck; move to RESP.
- REQ-011 XFER, OPB_retry=1 without xferAck: drop M_select next cycle; increment retry count; if the new count exceeds C_MAX_RETRY, move to RESP with rsp_err=1, else to REQ.
- REQ-012 xferAck and retry in the same cycle: xferAck wins.
- REQ-013 Timeout counter: cleared on XFER entry; increments each XFER cycle with OPB_toutSup=0; holds while toutSup=1; reaching C_TIMEOUT moves to RESP with rsp_tout=1, rsp_err=0.
- REQ-014 RESP: rsp_valid=1 exactly one cycle, no backpressure; then IDLE. rsp_rdata/rsp_err/rsp_tout hold until the next RESP.
- REQ-015 Writes: rsp_rdata unchanged.
- REQ-016 Outside XFER: M_ABus, M_BE, M_DBus, M_RNW SHALL be all-zero (OR-bus rule); M_seqAddr and M_busLock tied 0.
- REQ-017 Latency: command accept to M_select=1 is 2 cycles with immediate grant.
- REQ-018 cmd_valid outside IDLE SHALL be ignored.

Reset
- REQ-019 OPB_Rst_n=0 SHALL asynchronously force IDLE; all outputs 0 except cmd_ready=1 after release; counters and latched command cleared.
- REQ-020 Reset mid-XFER SHALL drop M_select and M_request immediately and produce no rsp_valid.

Structure
- REQ-021 State encoding, bus-width constants and default C_TIMEOUT/C_MAX_RETRY SHALL live in a shared package opb_master_pkg.
- REQ-022 The timeout counter SHALL be one sub-module, opb_tout_counter (clear, enable, hold, terminal-count output).

Verification
- REQ-023 Read 0x01008400, grant at once, xferAck on 3rd XFER cycle with OPB_DBus=0xDEADBEEF -> rsp_valid pulse, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_tout=0.
- REQ-024 Write 0x01008404 data 0x12345678 BE=0xF -> M_DBus=0x12345678 only while M_select=1; rsp_valid with rsp_err=0.
- REQ-025 Slave never acks, toutSup=0 -> rsp_tout=1 after exactly 16 XFER cycles; with toutSup held high 40 cycles then ack -> normal completion, rsp_tout=0.
- REQ-026 OPB_retry on 4 successive attempts -> 4 REQ phases, then rsp_err=1; retry twice then ack -> success.
- REQ-027 Grant delayed 5 cycles -> M_request high exactly 5 cycles; M_ABus zero until M_select.
- REQ-028 OPB_Rst_n low during XFER -> M_select=0 in same cycle; no rsp_valid; cmd_ready=1 after release.
